sqwave_ctrl: RTL and testbench

Programmable square-wave sequencer for the clocking fundamentals area. It accepts a half-period and period-count configuration over a valid/ready handshake and drives a registered square wave on `wave_o`, one `clk` cycle per tick. It also produces single-cycle rise/fall strobes and a completion pulse. It can run a fixed burst or free-run until stopped, and a new configuration can be queued while running so it takes effect at the next period boundary without a glitch.

---
 rtl/sqwave_pkg.sv | 24 ++
 rtl/sqwave_half_cnt.sv | 37 +++
 rtl/sqwave_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sqwave_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sqwave_pkg.sv
// Shared types and defaults for the square-wave sequencer.
// The cfg_t fields are sized by the default widths below.
package sqwave_pkg;

    localparam int SQ_CNT_W = 16;
    localparam int SQ_PER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP
    } state_t;

    typedef struct packed {
        logic [SQ_CNT_W-1:0] half;
        logic [SQ_PER_W-1:0] periods;
    } cfg_t;

    // A half-period of zero would never toggle, so it runs as one cycle.
    function automatic logic [SQ_CNT_W-1:0] clamp_half(input logic [SQ_CNT_W-1:0] h);
        return (h == '0) ? SQ_CNT_W'(1) : h;
    endfunction

endpackage

// File: rtl/sqwave_half_cnt.sv
// Loadable down-counter timing one phase of the square wave.
// Holds at zero rather than wrapping; the controller reloads it there.
module sqwave_half_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sqwave_ctrl.sv
// Square-wave sequencer: burst or free-run, stop request, and a shadow
// configuration that takes over at the next period boundary.
module sqwave_ctrl
    import sqwave_pkg::*;
#(
    parameter int CNT_W = SQ_CNT_W,
    parameter int PER_W = SQ_PER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [PER_W-1:0] cfg_periods,
    input  logic             stop_i,
    output logic             wave_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t state_q, state_d;
    cfg_t   cfg_q, cfg_d, shadow_q, shadow_d, cfg_in, cfg_next;
    logic   pend_q, pend_d;
    logic   wave_q, wave_d, rise_q, rise_d, fall_q, fall_d, done_q, done_d;

    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic             busy, accept, phase_end, boundary, apply, finish;

    always_comb begin
        cfg_in.half    = clamp_half(cfg_half);
        cfg_in.periods = cfg_periods;
        cfg_next       = pend_q ? shadow_q : cfg_in;
    end

    always_comb begin
        unique case (state_q)
            ST_IDLE: cfg_ready = 1'b1;
            ST_RUN:  cfg_ready = !pend_q;
            default: cfg_ready = 1'b0;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign phase_end = busy && cnt_zero;
    assign boundary  = phase_end && !wave_q;
    // A config accepted on the boundary cycle itself applies there too.
    assign apply     = (state_q == ST_RUN) && boundary && !stop_i && (pend_q || accept);
    assign finish    = boundary && !apply
                       && ((state_q == ST_STOP) || (cfg_q.periods == PER_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN: begin
                if (finish)      state_d = ST_IDLE;
                else if (stop_i) state_d = ST_STOP;
            end
            ST_STOP: if (finish) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_d        = cfg_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        wave_d       = wave_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = cfg_q.half - CNT_W'(1);

        if (state_q == ST_IDLE) begin
            pend_d = 1'b0;
            if (accept) begin
                cfg_d        = cfg_in;
                cnt_load     = 1'b1;
                cnt_load_val = cfg_in.half - CNT_W'(1);
                wave_d       = 1'b1;
                rise_d       = 1'b1;
            end
        end else begin
            if (state_q == ST_RUN) begin
                if (stop_i) begin
                    pend_d = 1'b0;
                end else if (accept && !apply) begin
                    pend_d   = 1'b1;
                    shadow_d = cfg_in;
                end
            end

            if (phase_end) begin
                cnt_load = 1'b1;
                if (wave_q) begin
                    wave_d = 1'b0;
                    fall_d = 1'b1;
                end else if (finish) begin
                    cnt_load = 1'b0;
                    wave_d   = 1'b0;
                    done_d   = 1'b1;
                    pend_d   = 1'b0;
                end else begin
                    wave_d = 1'b1;
                    rise_d = 1'b1;
                    if (apply) begin
                        // The new count replaces the remaining one; this boundary is not counted.
                        cfg_d        = cfg_next;
                        cnt_load_val = cfg_next.half - CNT_W'(1);
                        pend_d       = 1'b0;
                    end else if (cfg_q.periods != '0) begin
                        cfg_d.periods = cfg_q.periods - PER_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q    <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            wave_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            wave_q   <= wave_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            done_q   <= done_d;
        end
    end

    sqwave_half_cnt #(.W(CNT_W)) u_half_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (busy),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    assign wave_o = wave_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign busy_o = busy;
    assign done_o = done_q;

endmodule

// File: tb/tb_sqwave_ctrl.sv
// Self-checking bench for sqwave_ctrl: directed scenarios with fixed
// expected waveforms, then random stimulus against a period-position model.
module tb_sqwave_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_half;
    logic [7:0]  cfg_periods;
    logic        stop_i;
    logic        wave_o, rise_o, fall_o, busy_o, done_o;

    always #5 clk = ~clk;

    sqwave_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_half    (cfg_half),
        .cfg_periods (cfg_periods),
        .stop_i      (stop_i),
        .wave_o      (wave_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: position inside the current period, wave high while pos < h.
    bit m_active, m_stopping, m_pend, m_done;
    int m_pos, m_h, m_n, m_sh_h, m_sh_n;

    task automatic model_reset();
        m_active = 0; m_stopping = 0; m_pend = 0; m_done = 0;
        m_pos = 0; m_h = 1; m_n = 0; m_sh_h = 1; m_sh_n = 0;
    endtask

    function automatic bit model_ready();
        if (!m_active)  return 1'b1;
        if (m_stopping) return 1'b0;
        return !m_pend;
    endfunction

    // {cfg_ready, wave, rise, fall, busy, done}
    function automatic logic [5:0] model_outputs();
        bit w, r, f;
        w = m_active && (m_pos < m_h);
        r = m_active && (m_pos == 0);
        f = m_active && (m_pos == m_h);
        return {model_ready(), w, r, f, m_active, m_done};
    endfunction

    task automatic model_edge();
        bit acc, bnd, st, app;
        int hh, pp;
        acc = cfg_valid && model_ready();
        hh  = (cfg_half == 0) ? 1 : int'(cfg_half);
        pp  = int'(cfg_periods);
        m_done = 0;
        if (!m_active) begin
            if (acc) begin
                m_active = 1; m_stopping = 0; m_pend = 0;
                m_h = hh; m_n = pp; m_pos = 0;
            end
        end else if (m_stopping) begin
            if (m_pos == 2 * m_h - 1) begin
                m_active = 0; m_stopping = 0; m_done = 1;
            end else begin
                m_pos++;
            end
        end else begin
            bnd = (m_pos == 2 * m_h - 1);
            st  = stop_i;
            app = bnd && !st && (m_pend || acc);
            if (bnd) begin
                if (app) begin
                    if (m_pend) begin m_h = m_sh_h; m_n = m_sh_n; end
                    else        begin m_h = hh;     m_n = pp;     end
                    m_pend = 0;
                    m_pos  = 0;
                end else if (m_n == 1) begin
                    m_active = 0; m_done = 1; m_pend = 0;
                end else begin
                    if (m_n > 0) m_n--;
                    m_pos = 0;
                end
            end else begin
                m_pos++;
            end
            if (m_active) begin
                if (st) begin
                    m_stopping = 1; m_pend = 0;
                end else if (acc && !app) begin
                    m_pend = 1; m_sh_h = hh; m_sh_n = pp;
                end
            end
        end
    endtask

    // One clock: compare this cycle's outputs, drive inputs, advance model and DUT.
    task automatic cycle(input bit v, input int hh, input int pp, input bit st);
        check("outputs", 32'({cfg_ready, wave_o, rise_o, fall_o, busy_o, done_o}),
              32'(model_outputs()));
        cfg_valid   = v;
        cfg_half    = 16'(hh);
        cfg_periods = 8'(pp);
        stop_i      = st;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] cap_w, cap_r, cap_f, cap_b, cap_d, cap_rdy;

    task automatic capture(input int first, input int last, input int stop_at,
                           input int v_at, input int v_half, input int v_per);
        cap_w = '0; cap_r = '0; cap_f = '0; cap_b = '0; cap_d = '0; cap_rdy = '0;
        for (int c = first; c <= last; c++) begin
            cap_w[c]   = wave_o;
            cap_r[c]   = rise_o;
            cap_f[c]   = fall_o;
            cap_b[c]   = busy_o;
            cap_d[c]   = done_o;
            cap_rdy[c] = cfg_ready;
            cycle(c == v_at, v_half, v_per, c == stop_at);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_half = '0; cfg_periods = '0; stop_i = 1'b0;
        model_reset();
        #2;
        check("reset_outputs", 32'({cfg_ready, wave_o, rise_o, fall_o, busy_o, done_o}), 32'h20);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 0);

        // Burst: half=3, periods=2, accept in cycle 0.
        cycle(1, 3, 2, 0);
        capture(1, 13, -1, -1, 0, 0);
        check("burst_wave", 32'(cap_w[13:1]), 32'(13'b0000111000111));
        check("burst_rise", 32'(cap_r[13:1]), 32'(13'b0000001000001));
        check("burst_fall", 32'(cap_f[13:1]), 32'(13'b0001000001000));
        check("burst_done", 32'(cap_d[13:1]), 32'(13'b1000000000000));
        check("burst_idle_ready", 32'(cap_rdy[13]), 32'd1);

        // Clamp: half=0 behaves as half=1.
        cycle(1, 0, 1, 0);
        capture(1, 3, -1, -1, 0, 0);
        check("clamp_wave", 32'(cap_w[3:1]), 32'(3'b001));
        check("clamp_edges", 32'({cap_r[2:1], cap_f[2:1]}), 32'(4'b0110));
        check("clamp_done", 32'(cap_d[3:1]), 32'(3'b100));

        // Free-run, stop during the low phase.
        cycle(1, 2, 0, 0);
        capture(1, 6, 3, -1, 0, 0);
        check("stop_low_done", 32'(cap_d[6:1]), 32'(6'b010000));
        check("stop_low_busy", 32'(cap_b[6:1]), 32'(6'b001111));

        // Free-run, stop during a high phase: one full period follows.
        cycle(1, 2, 0, 0);
        capture(1, 10, 5, -1, 0, 0);
        check("stop_high_wave", 32'(cap_w[9:1]), 32'(9'b000110011));
        check("stop_high_done", 32'(cap_d[10:1]), 32'(10'b0100000000));

        // Queued reconfig mid-high-phase; a second offer while pending is refused.
        cycle(1, 4, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 2, 0);
        capture(3, 14, -1, 4, 7, 5);
        check("queue_ready", 32'(cap_rdy[9:3]), 32'(7'b1000000));
        check("queue_wave", 32'(cap_w[13:9]), 32'(5'b00101));
        check("queue_rise", 32'(cap_r[13:9]), 32'(5'b00101));
        check("queue_done", 32'(cap_d[14:3]), 32'(12'b010000000000));

        // Stop and accept in the same RUN cycle: stop wins, half stays 3.
        cycle(1, 3, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 1, 1);
        capture(3, 8, -1, -1, 0, 0);
        check("conflict_wave", 32'(cap_w[7:3]), 32'(5'b00001));
        check("conflict_ready", 32'(cap_rdy[6:3]), 32'(4'b0000));
        check("conflict_done", 32'(cap_d[8:3]), 32'(6'b010000));

        // Asynchronous reset in the middle of a high phase.
        cycle(1, 5, 0, 0);
        cycle(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 32'({cfg_ready, wave_o, rise_o, fall_o, busy_o, done_o}), 32'h20);
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle(0, 3, 1, 0);
        check("post_reset_wave", 32'(wave_o), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 40; i++) cycle(0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
